idle_seq: RTL and testbench
===========================

# idle_seq

Core-side IDLE sequencer that sits directly upstream of the clock controller. It turns an executed IDLE instruction into the `IDLE_ST_h` / `IDLE_ST` / `IRE[3:0]` handshake the clock controller consumes, and stalls the pipeline while idle. It selects the wake condition (interrupt, trap, ICE, or the clock controller's `Awake`) and sequences the return to normal execution.

## Interface
Parameters:
- `EXIT_CYC`, default 2: number of EXIT-state cycles (1..7) before the pipeline resumes.
- `WDOG_W`, default 16: width of the watchdog counter (used only with `IDLE_WDOG_EN`).

Ports:
- `DSPCLK` in 1: core clock (the gated/slowed DSPCLK from the clock controller).
- `PRST` in 1: reset, asynchronous, active-high; clock DSPCLK.
- `HRST` in 1: synchronous soft reset; forces RUN.
- `IDLE_go` in 1: one-cycle pulse from the decoder when an IDLE instruction executes.
- `IDLE_n` in 4: IDLE operand. [2:0] are the wake-interrupt enables; [3]=1 selects sleep (power-down), [3]=0 selects standby.
- `INT_req` in 3: pending interrupt levels.
- `TRAP_R_L` in 1: trap-return pulse.
- `ICE_wakeup` in 1: ICE wake request.
- `Awake` in 1: wake from the clock controller after oscillator restart.
- `WDOG_lim` in `WDOG_W`: watchdog limit (present only with `IDLE_WDOG_EN`).
- `IDLE_ST_h` out 1: high in ENTER and IDLE.
- `IDLE_ST` out 1: high in IDLE only.
- `IRE` out 4: latched `IDLE_n`.
- `STALL` out 1: pipeline hold.
- `IDLE_done` out 1: one-cycle pulse on resuming RUN.
- `WAKE_src` out 3: code of the last wake cause.

## Operation
- States: RUN, ENTER, IDLE, EXIT. All state and outputs are registered.
- Reset values (PRST async, or HRST sync): state=RUN; `IDLE_ST_h`=0, `IDLE_ST`=0, `IRE`=0, `STALL`=0, `IDLE_done`=0, `WAKE_src`=0; wake_pend cleared; exit counter=0.
- RUN: on `IDLE_go`, latch `IRE`<=`IDLE_n`, clear `WAKE_src`, go to ENTER. `IDLE_go` is ignored in every other state.
- ENTER: exactly one cycle, then unconditionally go to IDLE.
  - Wake events seen during ENTER are latched into wake_pend.
- IDLE: leave when wake = wake_pend OR a live wake condition:
  - Standby (`IRE[3]`=0): `|(INT_req & IRE[2:0])`, `TRAP_R_L`, or `ICE_wakeup`.
  - Sleep (`IRE[3]`=1): `Awake` only. Interrupts and traps are ignored.
- `WAKE_src` codes: 1 interrupt, 2 trap, 3 Awake, 4 ICE, 5 watchdog. Priority when several are simultaneous: ICE > Awake > trap > interrupt > watchdog.
- EXIT: counts `EXIT_CYC` cycles, then goes to RUN. `IRE` clears on RUN entry.
- `STALL` is high in ENTER, IDLE and EXIT.
- The exit counter is 3 bits; it is never compared beyond `EXIT_CYC`, so it does not wrap.

## Timing
- `IDLE_go` at cycle N: ENTER at N+1 (`IDLE_ST_h`=1, `STALL`=1); IDLE at N+2 (`IDLE_ST`=1).
- `IDLE_ST_h` leads `IDLE_ST` by exactly one cycle. The clock controller samples STBY/SLEEP on this edge.
- Wake sampled in IDLE at cycle M: EXIT at M+1 (`IDLE_ST`=`IDLE_ST_h`=0); RUN at M+1+`EXIT_CYC` with `IDLE_done`=1 for that single cycle.
- Minimum IDLE dwell is 1 cycle (when wake_pend is set).
- In sleep, DSPCLK stops; the state machine holds in IDLE until `Awake` arrives.
- `HRST` or `PRST` mid-sequence aborts to RUN with no `IDLE_done` pulse.

## Configuration
- `IDLE_WDOG_EN` defined: adds a `WDOG_W`-bit counter.
  - Clears on IDLE entry and increments each DSPCLK in IDLE.
  - When it reaches `WDOG_lim` (and `WDOG_lim`≠0), it forces an exit with `WAKE_src`=5.
  - It counts only while DSPCLK runs, so it is frozen in sleep.
  - It saturates and does not wrap.
- `IDLE_WDOG_EN` undefined: no counter, no `WDOG_lim` port; code 5 is never produced.

## Structure
- Package `idle_pkg`: state encoding (RUN=0, ENTER=1, IDLE=2, EXIT=3) and the `WAKE_src` code constants.
- Sub-module `idle_wdog`: watchdog counter with clear, enable, limit and expire ports. It is instantiated only under `IDLE_WDOG_EN`.

## Test plan
- Standby, interrupt wake: `IDLE_n`=4'b0010, `IDLE_go` at cycle 10; `INT_req`=3'b010 at cycle 20.
  - Expect `IDLE_ST_h` from 11, `IDLE_ST` over 12–20, EXIT over 21–22, `IDLE_done` at 23, `WAKE_src`=1.
- Masked interrupt: `IDLE_n`=4'b0001, `INT_req`=3'b100.
  - Expect it stays in IDLE; then `TRAP_R_L` pulse leads to exit with `WAKE_src`=2.
- Sleep: `IDLE_n`=4'b1111.
  - `INT_req`=3'b111 and `TRAP_R_L` must not wake; an `Awake` pulse leads to EXIT next cycle with `WAKE_src`=3.
- Wake during ENTER: `TRAP_R_L` pulses on the ENTER cycle.
  - Expect IDLE lasts exactly 1 cycle, then exit with `WAKE_src`=2.
- Simultaneous `ICE_wakeup` and `INT_req` in IDLE: expect `WAKE_src`=4.
  - Then assert PRST mid-EXIT: all outputs go to 0 immediately, with no `IDLE_done`.
- With `IDLE_WDOG_EN`, `WDOG_lim`=16'd5, no wake sources:
  - Expect exit after 5 IDLE cycles with `WAKE_src`=5.

Source files
------------

// File: rtl/idle_pkg.sv
// Shared types for the IDLE sequencer: state encoding, wake-cause codes
// and the wake-cause bundle with its priority encoder.
package idle_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_ENTER = 2'd1,
        S_IDLE  = 2'd2,
        S_EXIT  = 2'd3
    } state_t;

    localparam logic [2:0] WK_NONE  = 3'd0;
    localparam logic [2:0] WK_INT   = 3'd1;
    localparam logic [2:0] WK_TRAP  = 3'd2;
    localparam logic [2:0] WK_AWAKE = 3'd3;
    localparam logic [2:0] WK_ICE   = 3'd4;
    localparam logic [2:0] WK_WDOG  = 3'd5;

    typedef struct packed {
        logic ice;
        logic awake;
        logic trap;
        logic intr;
        logic wdog;
    } wake_t;

    // ICE > Awake > trap > interrupt > watchdog
    function automatic logic [2:0] wake_code(input wake_t w);
        if (w.ice)        return WK_ICE;
        else if (w.awake) return WK_AWAKE;
        else if (w.trap)  return WK_TRAP;
        else if (w.intr)  return WK_INT;
        else if (w.wdog)  return WK_WDOG;
        else              return WK_NONE;
    endfunction

endpackage

// File: rtl/idle_seq_wdog.sv
// Saturating IDLE watchdog: cleared before IDLE, counts while enabled,
// flags expiry on the cycle the count reaches the limit.
module idle_wdog #(
    parameter int W = 16
) (
    input  logic         DSPCLK,
    input  logic         PRST,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] lim,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge DSPCLK or posedge PRST) begin
        if (PRST)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != '1)
            cnt <= cnt + W'(1);
    end

    // The cycle holding lim-1 is the lim-th IDLE cycle.
    assign expire = en && (lim != '0) && (cnt >= lim - W'(1));

endmodule

// File: rtl/idle_seq.sv
// IDLE sequencer: drives IDLE_ST_h/IDLE_ST/IRE to the clock controller.
// Define IDLE_WDOG_EN to add the watchdog exit path (idle_wdog).
module idle_seq
    import idle_pkg::*;
#(
    parameter int EXIT_CYC = 2,
    parameter int WDOG_W   = 16
) (
    input  logic              DSPCLK,
    input  logic              PRST,
    input  logic              HRST,
    input  logic              IDLE_go,
    input  logic [3:0]        IDLE_n,
    input  logic [2:0]        INT_req,
    input  logic              TRAP_R_L,
    input  logic              ICE_wakeup,
    input  logic              Awake,
`ifdef IDLE_WDOG_EN
    input  logic [WDOG_W-1:0] WDOG_lim,
`endif
    output logic              IDLE_ST_h,
    output logic              IDLE_ST,
    output logic [3:0]        IRE,
    output logic              STALL,
    output logic              IDLE_done,
    output logic [2:0]        WAKE_src
);

    if (EXIT_CYC < 1 || EXIT_CYC > 7 || WDOG_W < 1) begin : g_bad_param
        $error("idle_seq: parameter out of range");
    end

    state_t     state, nstate;
    wake_t      pend, n_pend, live, all;
    logic [2:0] cnt, n_cnt, n_src;
    logic [3:0] n_ire;
    logic       n_done, wdog_exp;

`ifdef IDLE_WDOG_EN
    idle_wdog #(.W(WDOG_W)) u_wdog (
        .DSPCLK (DSPCLK),
        .PRST   (PRST),
        .clr    ((state == S_ENTER) || HRST),
        .en     (state == S_IDLE),
        .lim    (WDOG_lim),
        .expire (wdog_exp)
    );
`else
    assign wdog_exp = 1'b0;
`endif

    // Sleep only honours Awake; standby honours masked ints, trap and ICE.
    always_comb begin
        live = '0;
        if (IRE[3]) begin
            live.awake = Awake;
        end else begin
            live.intr = |(INT_req & IRE[2:0]);
            live.trap = TRAP_R_L;
            live.ice  = ICE_wakeup;
        end
        live.wdog = wdog_exp;
        all = wake_t'(pend | live);
    end

    always_comb begin
        nstate = state;
        n_ire  = IRE;
        n_src  = WAKE_src;
        n_pend = pend;
        n_cnt  = '0;
        n_done = 1'b0;
        unique case (state)
            S_RUN: begin
                n_pend = '0;
                n_ire  = '0;
                if (IDLE_go) begin
                    nstate = S_ENTER;
                    n_ire  = IDLE_n;
                    n_src  = WK_NONE;
                end
            end
            S_ENTER: begin
                nstate = S_IDLE;
                n_pend = wake_t'(pend | live);
            end
            S_IDLE: begin
                if (|all) begin
                    nstate = S_EXIT;
                    n_src  = wake_code(all);
                    n_pend = '0;
                end
            end
            S_EXIT: begin
                if (cnt == 3'(EXIT_CYC - 1)) begin
                    nstate = S_RUN;
                    n_ire  = '0;
                    n_done = 1'b1;
                end else begin
                    n_cnt = cnt + 3'd1;
                end
            end
            default: nstate = S_RUN;
        endcase
        if (HRST) begin
            nstate = S_RUN;
            n_ire  = '0;
            n_src  = '0;
            n_pend = '0;
            n_cnt  = '0;
            n_done = 1'b0;
        end
    end

    always_ff @(posedge DSPCLK or posedge PRST) begin
        if (PRST) begin
            state     <= S_RUN;
            pend      <= '0;
            cnt       <= '0;
            IRE       <= '0;
            WAKE_src  <= '0;
            IDLE_ST_h <= 1'b0;
            IDLE_ST   <= 1'b0;
            STALL     <= 1'b0;
            IDLE_done <= 1'b0;
        end else begin
            state     <= nstate;
            pend      <= n_pend;
            cnt       <= n_cnt;
            IRE       <= n_ire;
            WAKE_src  <= n_src;
            IDLE_ST_h <= (nstate == S_ENTER) || (nstate == S_IDLE);
            IDLE_ST   <= (nstate == S_IDLE);
            STALL     <= (nstate != S_RUN);
            IDLE_done <= n_done;
        end
    end

endmodule

// File: tb/tb_idle_seq.sv
// Scoreboard bench for idle_seq: stimulus queues expected handshake
// edges, a negedge monitor pops and compares them as they appear.
module tb_idle_seq;

    logic        DSPCLK = 1'b0;
    logic        PRST = 1'b1;
    logic        HRST = 1'b0;
    logic        IDLE_go = 1'b0;
    logic [3:0]  IDLE_n = '0;
    logic [2:0]  INT_req = '0;
    logic        TRAP_R_L = 1'b0;
    logic        ICE_wakeup = 1'b0;
    logic        Awake = 1'b0;
`ifdef IDLE_WDOG_EN
    logic [15:0] WDOG_lim = '0;
`endif
    logic        IDLE_ST_h, IDLE_ST, STALL, IDLE_done;
    logic [3:0]  IRE;
    logic [2:0]  WAKE_src;

    idle_seq #(.EXIT_CYC(2), .WDOG_W(16)) dut (
        .DSPCLK     (DSPCLK),
        .PRST       (PRST),
        .HRST       (HRST),
        .IDLE_go    (IDLE_go),
        .IDLE_n     (IDLE_n),
        .INT_req    (INT_req),
        .TRAP_R_L   (TRAP_R_L),
        .ICE_wakeup (ICE_wakeup),
        .Awake      (Awake),
`ifdef IDLE_WDOG_EN
        .WDOG_lim   (WDOG_lim),
`endif
        .IDLE_ST_h  (IDLE_ST_h),
        .IDLE_ST    (IDLE_ST),
        .IRE        (IRE),
        .STALL      (STALL),
        .IDLE_done  (IDLE_done),
        .WAKE_src   (WAKE_src)
    );

    always #5 DSPCLK = ~DSPCLK;

    int cyc = 0;
    always @(posedge DSPCLK) cyc++;

    localparam int K_HRISE = 0;
    localparam int K_SRISE = 1;
    localparam int K_SFALL = 2;
    localparam int K_DONE  = 3;

    typedef struct {
        int         kind;
        int         at;
        logic [2:0] src;
    } ev_t;

    ev_t q[$];
    int  tests = 0;
    int  fails = 0;

    function automatic ev_t mk(int kind, int at, logic [2:0] src);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        e.src  = src;
        return e;
    endfunction

    // Standard sequence: go at n, wake sampled at m.
    task automatic expect_seq(int n, int m, logic [2:0] src);
        q.push_back(mk(K_HRISE, n + 1, 3'd0));
        q.push_back(mk(K_SRISE, n + 2, 3'd0));
        q.push_back(mk(K_SFALL, m + 1, 3'd0));
        q.push_back(mk(K_DONE,  m + 3, src));
    endtask

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic see(int kind);
        ev_t e;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected event kind %0d at cycle %0d", kind, cyc);
            return;
        end
        e = q.pop_front();
        if (e.kind != kind || e.at != cyc ||
            (kind == K_DONE && WAKE_src !== e.src)) begin
            fails++;
            $display("FAIL event: got kind %0d cyc %0d src %0d expected kind %0d cyc %0d src %0d",
                     kind, cyc, WAKE_src, e.kind, e.at, e.src);
        end
    endtask

    logic p_h = 1'b0, p_st = 1'b0;
    always @(negedge DSPCLK) begin
        if (!p_h && IDLE_ST_h) see(K_HRISE);
        if (!p_st && IDLE_ST)  see(K_SRISE);
        if (p_st && !IDLE_ST)  see(K_SFALL);
        if (IDLE_done)         see(K_DONE);
        p_h  = IDLE_ST_h;
        p_st = IDLE_ST;
    end

    task automatic wait_cyc(int n);
        while (cyc < n) @(negedge DSPCLK);
    endtask

    task automatic go(int n, logic [3:0] op);
        wait_cyc(n);
        IDLE_n  = op;
        IDLE_go = 1'b1;
        wait_cyc(n + 1);
        IDLE_go = 1'b0;
    endtask

    initial begin
        #5000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        wait_cyc(2);
        chk("reset_outputs", int'({IDLE_ST_h, IDLE_ST, IRE, STALL, IDLE_done, WAKE_src}), 0);
        wait_cyc(3);
        PRST = 1'b0;

        // standby, interrupt wake
        expect_seq(10, 20, 3'd1);
        go(10, 4'b0010);
        chk("ire_latched", int'(IRE), 2);
        wait_cyc(15);
        chk("stall_in_idle", int'(STALL), 1);
        wait_cyc(20);
        INT_req = 3'b010;
        wait_cyc(21);
        INT_req = 3'b000;
        wait_cyc(24);
        chk("stall_after_done", int'(STALL), 0);
        chk("ire_cleared", int'(IRE), 0);

        // masked interrupt, then trap
        expect_seq(40, 52, 3'd2);
        go(40, 4'b0001);
        wait_cyc(45);
        INT_req = 3'b100;
        wait_cyc(50);
        chk("masked_int_holds", int'(IDLE_ST), 1);
        wait_cyc(52);
        TRAP_R_L = 1'b1;
        wait_cyc(53);
        TRAP_R_L = 1'b0;
        wait_cyc(56);
        INT_req = 3'b000;

        // sleep: only Awake wakes
        expect_seq(70, 85, 3'd3);
        go(70, 4'b1111);
        wait_cyc(74);
        INT_req = 3'b111;
        wait_cyc(76);
        TRAP_R_L = 1'b1;
        wait_cyc(77);
        TRAP_R_L = 1'b0;
        wait_cyc(80);
        chk("sleep_holds", int'(IDLE_ST), 1);
        wait_cyc(85);
        Awake = 1'b1;
        wait_cyc(86);
        Awake = 1'b0;
        wait_cyc(89);
        INT_req = 3'b000;

        // trap during ENTER: one-cycle IDLE dwell
        expect_seq(100, 102, 3'd2);
        go(100, 4'b0000);
        TRAP_R_L = 1'b1;
        wait_cyc(102);
        TRAP_R_L = 1'b0;

        // ICE + interrupt, then PRST mid-EXIT
        q.push_back(mk(K_HRISE, 121, 3'd0));
        q.push_back(mk(K_SRISE, 122, 3'd0));
        q.push_back(mk(K_SFALL, 126, 3'd0));
        go(120, 4'b0001);
        wait_cyc(125);
        ICE_wakeup = 1'b1;
        INT_req    = 3'b001;
        wait_cyc(126);
        ICE_wakeup = 1'b0;
        INT_req    = 3'b000;
        chk("ice_priority", int'(WAKE_src), 4);
        chk("stall_in_exit", int'(STALL), 1);
        wait_cyc(127);
        #1 PRST = 1'b1;
        #1 chk("prst_abort", int'({IDLE_ST_h, IDLE_ST, IRE, STALL, IDLE_done, WAKE_src}), 0);
        wait_cyc(129);
        PRST = 1'b0;

        // HRST while in IDLE aborts without done
        q.push_back(mk(K_HRISE, 141, 3'd0));
        q.push_back(mk(K_SRISE, 142, 3'd0));
        q.push_back(mk(K_SFALL, 144, 3'd0));
        go(140, 4'b0000);
        wait_cyc(143);
        HRST = 1'b1;
        wait_cyc(144);
        HRST = 1'b0;
        chk("hrst_stall", int'(STALL), 0);
        chk("hrst_h", int'(IDLE_ST_h), 0);

`ifdef IDLE_WDOG_EN
        // watchdog expiry after 5 IDLE cycles
        WDOG_lim = 16'd5;
        expect_seq(160, 166, 3'd5);
        go(160, 4'b0000);
        wait_cyc(172);
        WDOG_lim = 16'd0;
`endif

        wait_cyc(180);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
